// File: rtl/match_timer_pkg.sv
// match_timer shared types and constants.
// Counter width and the two-state run/idle encoding.
package match_timer_pkg;

    localparam int MT_WIDTH = 17;

    typedef enum logic {
        MT_IDLE = 1'b0,
        MT_RUN  = 1'b1
    } mt_state_t;

endpackage

// File: rtl/match_timer.sv
// Programmable interval timer: one-cycle tick on count match.
// One-shot or periodic, with a shadowed period reload.
module match_timer
    import match_timer_pkg::*;
#(
    parameter int WIDTH = MT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    mt_state_t        state;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_m1;
    logic [WIDTH-1:0] shadow;
    logic             pend;
    logic             mode;
    logic             ld;
    logic             match;

    // a zero period is never a legal interval, so such loads are dropped
    assign ld    = load && (period != '0);
    assign match = (count == target_m1);
    assign busy  = (state == MT_RUN);

    // timer state machine; all outputs come straight from registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MT_IDLE;
            target    <= '0;
            target_m1 <= '0;
            shadow    <= '0;
            pend      <= 1'b0;
            mode      <= 1'b0;
            count     <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= 1'b0;
            unique case (state)
                MT_IDLE: begin
                    count <= '0;
                    if (ld) begin
                        target    <= period;
                        target_m1 <= period - 1'b1;
                    end
                    if (start && !stop && (ld || target != '0)) begin
                        state <= MT_RUN;
                        mode  <= periodic;
                    end
                end
                MT_RUN: begin
                    if (stop) begin
                        state <= MT_IDLE;
                        count <= '0;
                        pend  <= 1'b0;
                    end else if (start) begin
                        count <= '0;
                        mode  <= periodic;
                        pend  <= 1'b0;
                        if (ld) begin
                            target    <= period;
                            target_m1 <= period - 1'b1;
                        end else if (pend) begin
                            target    <= shadow;
                            target_m1 <= shadow - 1'b1;
                        end
                    end else if (match) begin
                        tick  <= 1'b1;
                        count <= '0;
                        if (pend) begin
                            target    <= shadow;
                            target_m1 <= shadow - 1'b1;
                            pend      <= 1'b0;
                        end
                        if (!mode) begin
                            state <= MT_IDLE;
                            // a load landing on the final tick becomes the next interval
                            if (ld) begin
                                target    <= period;
                                target_m1 <= period - 1'b1;
                                pend      <= 1'b0;
                            end
                        end else if (ld) begin
                            shadow <= period;
                            pend   <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                        if (ld) begin
                            shadow <= period;
                            pend   <= 1'b1;
                        end
                    end
                end
                default: state <= MT_IDLE;
            endcase
        end
    end

endmodule
